// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter definitions:
// source-select encoding and age limit helper.
package cdb_arbiter_pkg;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_CH,
    SEL_MUL
  } cdb_sel_e;

  function automatic int age_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_age_arbiter.sv
// Oldest-first channel picker with
// saturated-age starvation flag.
module age_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int AGE_W  = 2
) (
  input  logic                    en,
  input  logic [NUM_CH-1:0]       ready,
  input  logic [NUM_CH*AGE_W-1:0] ages,
  output logic [NUM_CH-1:0]       grant,
  output logic                    starve
);

  localparam logic [AGE_W-1:0] AGE_MAX =
    AGE_W'(age_max(AGE_W));

  logic [NUM_CH-1:0] win;
  logic [AGE_W-1:0]  best;
  logic [AGE_W-1:0]  a;
  logic              found;

  // strict compare keeps ties on the lowest index
  always_comb begin
    win    = '0;
    best   = '0;
    a      = '0;
    found  = 1'b0;
    starve = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      a = ages[i*AGE_W +: AGE_W];
      if (ready[i] && (!found || a > best)) begin
        win    = '0;
        win[i] = 1'b1;
        best   = a;
        found  = 1'b1;
      end
      if (ready[i] && a == AGE_MAX)
        starve = 1'b1;
    end
    grant = win & {NUM_CH{en}};
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: single-cycle channels plus a
// fixed-latency multiplier onto a registered CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int AGE_W   = 2,
  parameter int MUL_LAT = 3,
  parameter logic [NUM_CH-1:0] LATE_MASK = 2'b10
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     flush_valid,
  input  logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*DATA_W-1:0] ch_dout,
  input  logic [NUM_CH*TAG_W-1:0]  ch_tag,
  input  logic [NUM_CH-1:0]        ch_branch,
  input  logic [NUM_CH-1:0]        ch_branch_taken,
  output logic [NUM_CH-1:0]        ch_issue,
  input  logic                     mul_ready,
  input  logic [DATA_W-1:0]        mul_dout,
  input  logic [TAG_W-1:0]         mul_tag,
  output logic                     mul_issue,
  output logic                     cdb_valid,
  output logic                     cdb_branch,
  output logic                     cdb_branch_taken,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [NUM_CH:0]          cdb_src,
  output logic [DATA_W-1:0]        cdb_data
);

  localparam logic [AGE_W-1:0] AGE_MAX =
    AGE_W'(age_max(AGE_W));

  logic [MUL_LAT-1:0]       mul_pipe;
  logic [MUL_LAT-1:0]       pipe_nxt;
  logic [NUM_CH*AGE_W-1:0]  ages_q;
  logic [NUM_CH*AGE_W-1:0]  ages_nxt;
  logic [NUM_CH-1:0]        grant;
  logic                     starve;
  logic                     tail;
  logic [AGE_W-1:0]         a;
  cdb_sel_e                 sel;

  logic [TAG_W-1:0]  g_tag;
  logic [DATA_W-1:0] g_dout;
  logic              g_br;
  logic              g_bt;

  logic              valid_nxt;
  logic              br_nxt;
  logic              bt_nxt;
  logic [TAG_W-1:0]  tag_nxt;
  logic [NUM_CH:0]   src_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [DATA_W-1:0] data_q;

  assign tail = mul_pipe[MUL_LAT-1];

  age_arbiter #(
    .NUM_CH (NUM_CH),
    .AGE_W  (AGE_W)
  ) u_age_arbiter (
    .en     (!tail && !flush_valid),
    .ready  (ch_ready),
    .ages   (ages_q),
    .grant  (grant),
    .starve (starve)
  );

  assign ch_issue  = grant;
  assign mul_issue = mul_ready & ~starve & ~flush_valid;

  always_comb begin
    pipe_nxt    = '0;
    pipe_nxt[0] = mul_issue;
    for (int i = 1; i < MUL_LAT; i++)
      pipe_nxt[i] = mul_pipe[i-1];
  end

  always_comb begin
    ages_nxt = ages_q;
    a        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      a = ages_q[i*AGE_W +: AGE_W];
      if (grant[i])
        ages_nxt[i*AGE_W +: AGE_W] = '0;
      else if (ch_ready[i] && a != AGE_MAX)
        ages_nxt[i*AGE_W +: AGE_W] = a + AGE_W'(1);
    end
  end

  always_comb begin
    g_tag  = '0;
    g_dout = '0;
    g_br   = 1'b0;
    g_bt   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      g_tag  = g_tag
             | (ch_tag[i*TAG_W +: TAG_W]
             & {TAG_W{grant[i]}});
      g_dout = g_dout
             | (ch_dout[i*DATA_W +: DATA_W]
             & {DATA_W{grant[i]}});
      g_br   = g_br | (ch_branch[i] & grant[i]);
      g_bt   = g_bt
             | (ch_branch_taken[i] & grant[i]);
    end
  end

  // grant is already masked by tail, so sources never overlap
  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      tail:   sel = SEL_MUL;
      |grant: sel = SEL_CH;
      default: sel = SEL_NONE;
    endcase
  end

  always_comb begin
    valid_nxt = 1'b0;
    br_nxt    = 1'b0;
    bt_nxt    = 1'b0;
    tag_nxt   = '0;
    src_nxt   = '0;
    data_nxt  = '0;
    case (sel)
      SEL_MUL: begin
        valid_nxt       = 1'b1;
        tag_nxt         = mul_tag;
        data_nxt        = mul_dout;
        src_nxt[NUM_CH] = 1'b1;
      end
      SEL_CH: begin
        valid_nxt = 1'b1;
        tag_nxt   = g_tag;
        data_nxt  = g_dout;
        br_nxt    = g_br;
        bt_nxt    = g_bt;
        src_nxt   = {1'b0, grant};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      mul_pipe         <= '0;
      ages_q           <= '0;
      cdb_valid        <= 1'b0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      cdb_tag          <= '0;
      cdb_src          <= '0;
      data_q           <= '0;
    end else if (flush_valid) begin
      mul_pipe         <= '0;
      ages_q           <= '0;
      cdb_valid        <= 1'b0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      cdb_tag          <= '0;
      cdb_src          <= '0;
      data_q           <= '0;
    end else begin
      mul_pipe         <= pipe_nxt;
      ages_q           <= ages_nxt;
      cdb_valid        <= valid_nxt;
      cdb_branch       <= br_nxt;
      cdb_branch_taken <= bt_nxt;
      cdb_tag          <= tag_nxt;
      cdb_src          <= src_nxt;
      data_q           <= data_nxt;
    end
  end

  // late channels deliver data a cycle after grant
  always_comb begin
    cdb_data = data_q;
    for (int i = 0; i < NUM_CH; i++)
      if (cdb_src[i] && LATE_MASK[i])
        cdb_data = ch_dout[i*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a
// cycle-stamped CDB scoreboard.
module tb_cdb_arbiter;

  logic        clock = 1'b0;
  logic        nreset;
  logic        flush_valid;
  logic [1:0]  ch_ready;
  logic [63:0] ch_dout;
  logic [9:0]  ch_tag;
  logic [1:0]  ch_branch;
  logic [1:0]  ch_branch_taken;
  logic [1:0]  ch_issue;
  logic        mul_ready;
  logic [31:0] mul_dout;
  logic [4:0]  mul_tag;
  logic        mul_issue;
  logic        cdb_valid;
  logic        cdb_branch;
  logic        cdb_branch_taken;
  logic [4:0]  cdb_tag;
  logic [2:0]  cdb_src;
  logic [31:0] cdb_data;

  cdb_arbiter dut (
    .clock            (clock),
    .nreset           (nreset),
    .flush_valid      (flush_valid),
    .ch_ready         (ch_ready),
    .ch_dout          (ch_dout),
    .ch_tag           (ch_tag),
    .ch_branch        (ch_branch),
    .ch_branch_taken  (ch_branch_taken),
    .ch_issue         (ch_issue),
    .mul_ready        (mul_ready),
    .mul_dout         (mul_dout),
    .mul_tag          (mul_tag),
    .mul_issue        (mul_issue),
    .cdb_valid        (cdb_valid),
    .cdb_branch       (cdb_branch),
    .cdb_branch_taken (cdb_branch_taken),
    .cdb_tag          (cdb_tag),
    .cdb_src          (cdb_src),
    .cdb_data         (cdb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [4:0]  tag;
    logic [2:0]  src;
    logic [31:0] data;
    logic        br;
    logic        bt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [10:0] exp_mul_v = 11'b100_0011_1111;
  logic [10:0] exp_ch1_v = 11'b110_0000_0111;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h",
             name, got, exp);
    end
  endtask

  task automatic push(input int c,
                      input logic [4:0] tag,
                      input logic [2:0] src,
                      input logic [31:0] data,
                      input logic br,
                      input logic bt);
    exp_t e;
    e.cyc  = c;
    e.tag  = tag;
    e.src  = src;
    e.data = data;
    e.br   = br;
    e.bt   = bt;
    exp_q.push_back(e);
  endtask

  task automatic sb();
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("cdb_valid", 64'(cdb_valid), 64'h1);
      chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
      chk("cdb_src", 64'(cdb_src), 64'(e.src));
      chk("cdb_data", 64'(cdb_data), 64'(e.data));
      chk("cdb_br", 64'(cdb_branch), 64'(e.br));
      chk("cdb_bt", 64'(cdb_branch_taken),
          64'(e.bt));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic step();
    sb();
    tick();
  endtask

  task automatic idle(input string name);
    chk(name, 64'(cdb_valid), 64'h0);
  endtask

  task automatic flush_clear();
    flush_valid = 1'b1;
    #1;
    step();
    flush_valid = 1'b0;
  endtask

  initial begin
    nreset          = 1'b0;
    flush_valid     = 1'b0;
    ch_ready        = 2'b11;
    ch_dout         = '0;
    ch_tag          = '0;
    ch_branch       = '0;
    ch_branch_taken = '0;
    mul_ready       = 1'b1;
    mul_dout        = '0;
    mul_tag         = '0;

    // reset: zero state, combinational grants still live
    #12;
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_tag", 64'(cdb_tag), 64'h0);
    chk("rst_src", 64'(cdb_src), 64'h0);
    chk("rst_data", 64'(cdb_data), 64'h0);
    chk("rst_ch_issue", 64'(ch_issue), 64'h1);
    chk("rst_mul_issue", 64'(mul_issue), 64'h1);
    mul_ready = 1'b0;
    ch_ready  = 2'b00;
    @(posedge clock);
    #1;
    nreset = 1'b1;

    // alternating tie-break with 1-cycle CDB lag
    ch_dout         = {32'hC1C1_0001, 32'hC0C0_0000};
    ch_branch       = 2'b01;
    ch_branch_taken = 2'b01;
    for (int k = 0; k < 4; k++) begin
      ch_ready = 2'b11;
      ch_tag   = {5'(2*k+1), 5'(2*k)};
      #1;
      if (k % 2 == 0) begin
        chk("alt_grant", 64'(ch_issue), 64'h1);
        push(cyc+1, 5'(2*k), 3'b001,
             32'hC0C0_0000, 1'b1, 1'b1);
      end else begin
        chk("alt_grant", 64'(ch_issue), 64'h2);
        push(cyc+1, 5'(2*k+1), 3'b010,
             32'hC1C1_0001, 1'b0, 1'b0);
      end
      step();
    end
    ch_ready        = 2'b00;
    ch_branch       = 2'b00;
    ch_branch_taken = 2'b00;
    #1;
    step();
    #1;
    idle("alt_idle");
    step();
    flush_clear();

    // multiplier latency and tail blocking
    mul_ready = 1'b1;
    #1;
    chk("mul_issue", 64'(mul_issue), 64'h1);
    chk("mul_ch_idle", 64'(ch_issue), 64'h0);
    step();
    mul_ready = 1'b0;
    #1;
    idle("mul_t1");
    step();
    #1;
    idle("mul_t2");
    step();
    mul_dout = 32'hDEAD_BEEF;
    mul_tag  = 5'h07;
    ch_ready = 2'b01;
    ch_tag   = {5'h00, 5'h03};
    ch_dout  = {32'h0, 32'h0000_0C0C};
    #1;
    chk("tail_block", 64'(ch_issue), 64'h0);
    idle("mul_t3");
    push(cyc+1, 5'h07, 3'b100,
         32'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    mul_dout = '0;
    mul_tag  = '0;
    #1;
    chk("post_tail", 64'(ch_issue), 64'h1);
    push(cyc+1, 5'h03, 3'b001,
         32'h0000_0C0C, 1'b0, 1'b0);
    step();
    ch_ready = 2'b00;
    #1;
    step();
    flush_clear();

    // starvation guard against back-to-back multiplies
    ch_tag  = {5'h01, 5'h00};
    ch_dout = {32'h0000_5555, 32'h0};
    for (int t = 0; t <= 10; t++) begin
      mul_ready = 1'b1;
      ch_ready  = 2'b10;
      mul_tag   = 5'(16 + t);
      mul_dout  = 32'hA000 + 32'(t);
      #1;
      chk("starve_ch", 64'(ch_issue),
          64'({exp_ch1_v[t], 1'b0}));
      chk("starve_mul", 64'(mul_issue),
          64'(exp_mul_v[t]));
      if (exp_ch1_v[t])
        push(cyc+1, 5'h01, 3'b010,
             32'h0000_5555, 1'b0, 1'b0);
      if (t >= 3 && t <= 8)
        push(cyc+1, 5'(16 + t), 3'b100,
             32'hA000 + 32'(t), 1'b0, 1'b0);
      step();
    end
    mul_ready = 1'b0;
    ch_ready  = 2'b00;
    #1;
    step();
    flush_clear();
    for (int t = 0; t < 3; t++) begin
      #1;
      idle("starve_drop");
      step();
    end

    // late forwarding vs registered data
    ch_ready = 2'b10;
    ch_tag   = {5'h0A, 5'h00};
    ch_dout  = '0;
    #1;
    chk("late_grant", 64'(ch_issue), 64'h2);
    push(cyc+1, 5'h0A, 3'b010,
         32'h0000_1234, 1'b0, 1'b0);
    step();
    ch_ready = 2'b00;
    ch_dout  = {32'h0000_1234, 32'h0};
    #1;
    sb();
    ch_dout = {32'h0000_5678, 32'h0};
    #1;
    chk("late_live", 64'(cdb_data), 64'h5678);
    tick();
    ch_ready = 2'b01;
    ch_tag   = {5'h00, 5'h0B};
    ch_dout  = {32'h0, 32'h0000_1111};
    #1;
    chk("reg_grant", 64'(ch_issue), 64'h1);
    push(cyc+1, 5'h0B, 3'b001,
         32'h0000_1111, 1'b0, 1'b0);
    step();
    ch_ready = 2'b00;
    ch_dout  = {32'h0, 32'h0000_2222};
    #1;
    step();
    flush_clear();

    // flush drops in-flight multiplies and ages
    ch_ready = 2'b11;
    ch_tag   = {5'h12, 5'h11};
    ch_dout  = {32'h0, 32'h0000_3333};
    #1;
    chk("pre_flush", 64'(ch_issue), 64'h1);
    push(cyc+1, 5'h11, 3'b001,
         32'h0000_3333, 1'b0, 1'b0);
    step();
    ch_ready  = 2'b00;
    mul_ready = 1'b1;
    mul_tag   = 5'h1E;
    mul_dout  = 32'hFFFF_0000;
    #1;
    chk("fl_mul_a", 64'(mul_issue), 64'h1);
    step();
    #1;
    chk("fl_mul_b", 64'(mul_issue), 64'h1);
    step();
    flush_valid = 1'b1;
    ch_ready    = 2'b11;
    #1;
    chk("flush_ch", 64'(ch_issue), 64'h0);
    chk("flush_mul", 64'(mul_issue), 64'h0);
    step();
    flush_valid = 1'b0;
    ch_ready    = 2'b00;
    mul_ready   = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1;
      idle("flush_drop");
      step();
    end
    ch_ready = 2'b11;
    #1;
    chk("flush_age", 64'(ch_issue), 64'h1);
    push(cyc+1, 5'h11, 3'b001,
         32'h0000_3333, 1'b0, 1'b0);
    step();
    ch_ready = 2'b00;
    #1;
    step();

    // async reset with a multiply in flight
    mul_ready = 1'b1;
    ch_ready  = 2'b01;
    #1;
    chk("pre_rst_mul", 64'(mul_issue), 64'h1);
    tick();
    mul_ready = 1'b0;
    ch_ready  = 2'b00;
    #1;
    chk("pre_rst_valid", 64'(cdb_valid), 64'h1);
    nreset = 1'b0;
    #1;
    chk("arst_valid", 64'(cdb_valid), 64'h0);
    chk("arst_src", 64'(cdb_src), 64'h0);
    chk("arst_tag", 64'(cdb_tag), 64'h0);
    chk("arst_data", 64'(cdb_data), 64'h0);
    tick();
    nreset   = 1'b1;
    mul_tag  = 5'h1F;
    mul_dout = 32'hFFFF_FFFF;
    for (int t = 0; t < 5; t++) begin
      #1;
      idle("rst_stale");
      step();
    end

    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
